sdpram_bist_ctrl: RTL and testbench

Synthesizable, self-checking test controller for the simple dual-port RAM IP cores (for example the 8x256 ICMP RX buffer), with configurable width, depth, read latency and data pattern. On `start` it fills every address with a selected pattern, reads every address back, and compares each read against the expected value. It reports pass/fail, a saturating error count and the first failing address. It sits beside the RAM under test, runs in a single clock domain (RAM write and read clocks tied to `wr_clk`), and replaces simulation-only checking so RAM integrity can also be exercised on board.

---
 rtl/sdpram_bist_pkg.sv | 37 +++
 rtl/sdpram_bist_rdpipe.sv | 38 +++
 rtl/sdpram_bist_ctrl.sv | 149 ++++++++++++++
 tb/tb_sdpram_bist_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_bist_pkg.sv
// Shared definitions for the simple dual-port RAM BIST controller.
// Holds the mode encodings, the controller state encoding and the data pattern generator.
// The pattern is built at PAT_MAX bits; callers cast it down to their DATA_WIDTH (1..PAT_MAX).
package sdpram_bist_pkg;

  localparam int PAT_MAX = 64;

  localparam logic [1:0] MODE_DESC = 2'd0;  // all-ones minus address
  localparam logic [1:0] MODE_ADDR = 2'd1;  // address as data
  localparam logic [1:0] MODE_CHK  = 2'd2;  // 1010... on even addresses, 0101... on odd
  localparam logic [1:0] MODE_NCHK = 2'd3;  // inverse checkerboard

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Truncating the PAT_MAX-bit result to DATA_WIDTH gives the right word for
  // every mode: ~addr keeps "all-ones minus address" modulo 2^DATA_WIDTH, and
  // the checkerboards are periodic in bit index.
  function automatic logic [PAT_MAX-1:0] pattern(input logic [PAT_MAX-1:0] addr,
                                                 input logic [1:0]         mode);
    logic [PAT_MAX-1:0] chk;
    chk = addr[0] ? {(PAT_MAX/2){2'b01}} : {(PAT_MAX/2){2'b10}};
    case (mode)
      MODE_DESC: return ~addr;
      MODE_ADDR: return addr;
      MODE_CHK:  return chk;
      default:   return ~chk;
    endcase
  endfunction

endpackage

// File: rtl/sdpram_bist_rdpipe.sv
// Read tag delay line: delays the read-issue strobe and address by RD_LAT cycles so they line up with RAM data.
// Latency: exactly RD_LAT cycles from in_vld/in_addr to out_vld/out_addr.
// No backpressure: shifts every cycle. Ports: wr_clk, tb_wr_rst, in_vld/in_addr (issue), out_vld/out_addr (compare tag).
module sdpram_bist_rdpipe
  import sdpram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  in_vld,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_vld,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  logic [RD_LAT-1:0]     vld_sr;
  logic [ADDR_WIDTH-1:0] addr_sr [RD_LAT];

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= in_vld;
      addr_sr[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  assign out_vld  = vld_sr[RD_LAT-1];
  assign out_addr = addr_sr[RD_LAT-1];

endmodule

// File: rtl/sdpram_bist_ctrl.sv
// Write-all / read-all BIST for a simple dual-port RAM: fills with a pattern, reads back, counts mismatches.
// Latency: done appears 2N+1+RD_LAT edges after the start edge (N = 2^ADDR_WIDTH).
// No backpressure: one address per cycle; start is ignored while busy.
// Ports: wr_clk/tb_wr_rst; start/mode control; busy/done/pass/err_cnt/first_err_* status; ram_* drive the RAM under test.
module sdpram_bist_ctrl
  import sdpram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int OUTPUT_REG = 0,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  first_err_vld,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int RD_LAT = (OUTPUT_REG != 0) ? 2 : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [1:0]            mode_q;
  logic                  rd_issue;
  logic                  drain_cnt;
  logic                  cmp_vld;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [ADDR_WIDTH-1:0] nxt_wr_addr;
  logic [DATA_WIDTH-1:0] nxt_wr_data;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  mism;
  logic [ERR_WIDTH-1:0]  err_nxt;

  sdpram_bist_rdpipe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_rdpipe (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .in_vld    (rd_issue),
    .in_addr   (ram_rd_addr),
    .out_vld   (cmp_vld),
    .out_addr  (cmp_addr)
  );

  // Write data is registered, so the pattern is computed for the address
  // about to be presented on the next cycle.
  always_comb begin
    nxt_wr_addr = ram_wr_addr + 1'b1;
    nxt_wr_data = DATA_WIDTH'(pattern(PAT_MAX'(nxt_wr_addr), mode_q));
    exp_data    = DATA_WIDTH'(pattern(PAT_MAX'(cmp_addr), mode_q));
    mism        = cmp_vld && (ram_rd_data != exp_data);
    err_nxt     = err_cnt;
    if (mism && (err_cnt != '1)) err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state          <= ST_IDLE;
      mode_q         <= '0;
      rd_issue       <= 1'b0;
      drain_cnt      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
      ram_wr_en      <= 1'b0;
      ram_wr_addr    <= '0;
      ram_wr_data    <= '0;
      ram_rd_addr    <= '0;
    end else begin
      // Compare side runs independently of the state; the start branch
      // below overrides these when a new test is launched.
      err_cnt <= err_nxt;
      if (mism && !first_err_vld) begin
        first_err_vld  <= 1'b1;
        first_err_addr <= cmp_addr;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_WRITE;
            mode_q         <= mode;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
            ram_wr_en      <= 1'b1;
            ram_wr_addr    <= '0;
            ram_wr_data    <= DATA_WIDTH'(pattern('0, mode));
          end
        end
        ST_WRITE: begin
          if (ram_wr_addr == LAST_ADDR) begin
            state     <= ST_GAP;
            ram_wr_en <= 1'b0;
          end else begin
            ram_wr_addr <= nxt_wr_addr;
            ram_wr_data <= nxt_wr_data;
          end
        end
        ST_GAP: begin
          state       <= ST_READ;
          ram_rd_addr <= '0;
          rd_issue    <= 1'b1;
        end
        ST_READ: begin
          if (ram_rd_addr == LAST_ADDR) begin
            state     <= ST_DRAIN;
            rd_issue  <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            ram_rd_addr <= ram_rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The last tagged word is compared on this same edge, so pass
          // must look at the updated count.
          if (drain_cnt == 1'(RD_LAT - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdpram_bist_ctrl.sv
// Bench for sdpram_bist_ctrl: two instances (RAM read latency 1 and 2) each beside a behavioural RAM
// with injectable faults; a table of full test runs plus hand sequences for reset abort and held start.
module tb_sdpram_bist_ctrl;

  localparam int F_NONE  = 0;
  localparam int F_STUCK = 1;  // address 0x10 stores bit 3 as 0
  localparam int F_ZERO  = 2;  // read data forced to 0x00

  logic       wr_clk = 1'b0;
  logic       tb_wr_rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [1:0] mode = 2'd0;
  int         fault = F_NONE;

  logic       busy0, done0, pass0, fvld0, wr_en0;
  logic [7:0] err0, faddr0, wr_addr0, wr_data0, rd_addr0, rd_data0;
  logic       busy1, done1, pass1, fvld1, wr_en1;
  logic [7:0] err1, faddr1, wr_addr1, wr_data1, rd_addr1, rd_data1;

  always #5 wr_clk = ~wr_clk;

  sdpram_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .OUTPUT_REG(0), .ERR_WIDTH(8)) dut0 (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start0), .mode(mode),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_addr(faddr0), .first_err_vld(fvld0),
    .ram_wr_en(wr_en0), .ram_wr_addr(wr_addr0), .ram_wr_data(wr_data0),
    .ram_rd_addr(rd_addr0), .ram_rd_data(rd_data0));

  sdpram_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .OUTPUT_REG(1), .ERR_WIDTH(8)) dut1 (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start1), .mode(mode),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_addr(faddr1), .first_err_vld(fvld1),
    .ram_wr_en(wr_en1), .ram_wr_addr(wr_addr1), .ram_wr_data(wr_data1),
    .ram_rd_addr(rd_addr1), .ram_rd_data(rd_data1));

  // Behavioural RAMs. 0xAA already has bit 3 set, so the stuck fault holds
  // that bit low to make it observable with the checkerboard.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] q0, q1a, q1b;

  always @(posedge wr_clk) begin
    if (wr_en0) mem0[wr_addr0] <= (fault == F_STUCK && wr_addr0 == 8'h10) ? (wr_data0 & 8'hF7) : wr_data0;
    if (wr_en1) mem1[wr_addr1] <= (fault == F_STUCK && wr_addr1 == 8'h10) ? (wr_data1 & 8'hF7) : wr_data1;
    q0  <= mem0[rd_addr0];
    q1a <= mem1[rd_addr1];
    q1b <= q1a;
  end
  assign rd_data0 = (fault == F_ZERO) ? 8'h00 : q0;
  assign rd_data1 = (fault == F_ZERO) ? 8'h00 : q1b;

  // View of whichever instance the current step targets.
  logic       sel = 1'b0;
  logic       s_busy, s_done, s_pass, s_fvld, s_wr_en;
  logic [7:0] s_err, s_faddr, s_wr_addr, s_wr_data, s_rd_addr;
  assign s_busy    = sel ? busy1    : busy0;
  assign s_done    = sel ? done1    : done0;
  assign s_pass    = sel ? pass1    : pass0;
  assign s_fvld    = sel ? fvld1    : fvld0;
  assign s_wr_en   = sel ? wr_en1   : wr_en0;
  assign s_err     = sel ? err1     : err0;
  assign s_faddr   = sel ? faddr1   : faddr0;
  assign s_wr_addr = sel ? wr_addr1 : wr_addr0;
  assign s_wr_data = sel ? wr_data1 : wr_data0;
  assign s_rd_addr = sel ? rd_addr1 : rd_addr0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       outreg;
    logic [1:0] mode;
    int         fault;
    logic [7:0] probe;
    logic [7:0] exp_wd;
    int         exp_edge;
    logic [7:0] exp_err;
    logic       exp_fvld;
    logic [7:0] exp_faddr;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[7];

  // Runs one full test on the selected instance and checks it against v.
  // mode is flipped right after the start edge; the latched mode must win.
  task automatic run_test(input vec_t v, input string tag);
    int         k;
    int         wr_cnt;
    logic [7:0] probe_dat;
    sel       = v.outreg;
    fault     = v.fault;
    mode      = v.mode;
    probe_dat = 8'hxx;
    wr_cnt    = 0;
    @(negedge wr_clk);
    if (v.outreg) start1 = 1'b1; else start0 = 1'b1;
    @(posedge wr_clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = v.mode ^ 2'b01;
    check({tag, ".busy_c0"}, 32'(s_busy), 32'd1);
    k = 0;
    while (!s_done && k < 1000) begin
      if (s_wr_en) begin
        wr_cnt++;
        if (s_wr_addr == v.probe) probe_dat = s_wr_data;
      end
      @(posedge wr_clk);
      #1;
      k++;
    end
    check({tag, ".done_edge"}, 32'(k), 32'(v.exp_edge));
    check({tag, ".wr_cycles"}, 32'(wr_cnt), 32'd256);
    check({tag, ".probe_wdata"}, 32'(probe_dat), 32'(v.exp_wd));
    check({tag, ".busy_done"}, 32'(s_busy), 32'd0);
    check({tag, ".err_cnt"}, 32'(s_err), 32'(v.exp_err));
    check({tag, ".pass"}, 32'(s_pass), 32'(v.exp_pass));
    check({tag, ".first_vld"}, 32'(s_fvld), 32'(v.exp_fvld));
    if (v.exp_fvld) check({tag, ".first_addr"}, 32'(s_faddr), 32'(v.exp_faddr));
  endtask

  initial begin
    int k;
    //          oreg mode fault    probe  wdata  edge err    fvld faddr  pass
    vecs[0] = '{1'b0, 2'd0, F_NONE,  8'h05, 8'hFA, 514, 8'd0,   1'b0, 8'h00, 1'b1};
    vecs[1] = '{1'b1, 2'd1, F_NONE,  8'h05, 8'h05, 515, 8'd0,   1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 2'd2, F_STUCK, 8'h10, 8'hAA, 514, 8'd1,   1'b1, 8'h10, 1'b0};
    vecs[3] = '{1'b0, 2'd2, F_ZERO,  8'h11, 8'h55, 514, 8'd255, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 2'd3, F_NONE,  8'h20, 8'h55, 514, 8'd0,   1'b0, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 2'd3, F_ZERO,  8'h21, 8'hAA, 515, 8'd255, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 2'd1, F_NONE,  8'hFF, 8'hFF, 514, 8'd0,   1'b0, 8'h00, 1'b1};

    // Reset state of both instances.
    #3;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst.busy", 32'(s_busy), 32'd0);
      check("rst.done", 32'(s_done), 32'd0);
      check("rst.pass", 32'(s_pass), 32'd0);
      check("rst.err_cnt", 32'(s_err), 32'd0);
      check("rst.first", 32'({s_fvld, s_faddr}), 32'd0);
      check("rst.wr", 32'({s_wr_en, s_wr_addr, s_wr_data}), 32'd0);
      check("rst.rd_addr", 32'(s_rd_addr), 32'd0);
    end
    repeat (3) @(negedge wr_clk);
    tb_wr_rst = 1'b0;

    for (int i = 0; i < 7; i++) run_test(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of the write phase aborts at once, then a fresh run passes.
    sel   = 1'b0;
    fault = F_NONE;
    mode  = 2'd0;
    @(negedge wr_clk);
    start0 = 1'b1;
    @(posedge wr_clk);
    #1;
    start0 = 1'b0;
    k = 0;
    while (wr_addr0 != 8'h40 && k < 300) begin
      @(posedge wr_clk);
      #1;
      k++;
    end
    check("abort.reach_0x40", 32'(k), 32'd64);
    #2;
    tb_wr_rst = 1'b1;
    #1;
    check("abort.busy", 32'(busy0), 32'd0);
    check("abort.wr_en", 32'(wr_en0), 32'd0);
    check("abort.done", 32'(done0), 32'd0);
    @(negedge wr_clk);
    tb_wr_rst = 1'b0;
    run_test(vecs[0], "post_abort");

    // start held high through a whole test and across the DONE edge.
    sel   = 1'b0;
    fault = F_ZERO;
    mode  = 2'd2;
    @(negedge wr_clk);
    start0 = 1'b1;
    @(posedge wr_clk);
    #1;
    k = 0;
    while (!done0 && k < 1000) begin
      @(posedge wr_clk);
      #1;
      k++;
    end
    check("held.done_edge", 32'(k), 32'd514);
    check("held.err_first", 32'(err0), 32'd255);
    check("held.busy_done", 32'(busy0), 32'd0);
    fault = F_NONE;
    @(posedge wr_clk);
    #1;
    check("held.restart_done", 32'(done0), 32'd0);
    check("held.restart_busy", 32'(busy0), 32'd1);
    check("held.restart_err", 32'(err0), 32'd0);
    check("held.restart_wr", 32'({wr_en0, wr_addr0, wr_data0}), 32'({1'b1, 8'h00, 8'hAA}));
    mode = 2'd1;
    k = 0;
    while (!done0 && k < 1000) begin
      @(posedge wr_clk);
      #1;
      k++;
    end
    start0 = 1'b0;
    check("held.second_edge", 32'(k), 32'd514);
    check("held.second_pass", 32'(pass0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
